// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the two-port memory arbiter
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data port arbiter onto one fixed-latency memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    port_t               r_port;
    port_t               r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_any_req;
    port_t               w_gnt_port;
    logic [ADDR_W-1:0]   w_req_addr;
    logic                w_misalign;
    logic                w_first;

    // On a tie the port that was not served last wins.
    assign w_any_req  = i_req | d_req;
    assign w_gnt_port = (d_req && (!i_req || r_last == PORT_I)) ? PORT_D : PORT_I;
    assign w_req_addr = (w_gnt_port == PORT_D) ? d_addr : i_addr;
    assign w_misalign = |w_req_addr[1:0];
    assign w_first    = (r_cnt == LAT_M1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m_en        = 1'b0;
        m_we        = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        i_done      = 1'b0;
        i_rdata     = '0;
        i_err       = 1'b0;
        d_done      = 1'b0;
        d_rdata     = '0;
        d_err       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = w_misalign ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                m_en    = 1'b1;
                m_we    = r_we && w_first;
                m_addr  = r_addr;
                m_wdata = r_wdata;
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                if (r_port == PORT_I) begin
                    i_done  = 1'b1;
                    i_rdata = r_rdata;
                    i_err   = r_err;
                end else begin
                    d_done  = 1'b1;
                    d_rdata = r_rdata;
                    d_err   = r_err;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Misaligned grants skip ACCESS entirely, so the response is fixed at grant time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_port  <= PORT_I;
            r_last  <= PORT_I;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_port  <= w_gnt_port;
                        r_addr  <= {w_req_addr[ADDR_W-1:2], 2'b00};
                        r_we    <= (w_gnt_port == PORT_D) ? d_we : 1'b0;
                        r_wdata <= (w_gnt_port == PORT_D) ? d_wdata : '0;
                        r_err   <= w_misalign;
                        r_rdata <= '0;
                        r_cnt   <= w_misalign ? '0 : LAT_M1;
                    end
                end
                ACCESS: begin
                    if (r_cnt == '0) begin
                        r_rdata <= r_we ? '0 : m_rdata;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    r_last <= r_port;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    logic              clk;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_done  (i_done),
        .i_rdata (i_rdata),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_done  (d_done),
        .d_rdata (d_rdata),
        .d_err   (d_err),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:63];

    always @(posedge clk) begin
        if (reset) begin
            mem[0]  <= 32'hCAFE_0000;
            mem[2]  <= 32'h8888_0008;
            mem[4]  <= 32'h0000_0000;
            mem[16] <= 32'h1234_5678;
        end else if (m_en) begin
            if (m_we) mem[m_addr[7:2]] <= m_wdata;
            else      m_rdata <= mem[m_addr[7:2]];
        end
    end

    int checks   = 0;
    int failures = 0;

    int          i_lat, d_lat, i_cnt, d_cnt, en_cnt, we_cnt, en_first;
    logic [31:0] i_rd, d_rd, we_addr_s;
    logic        i_er, d_er;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle 0 is the cycle in which the requests were first presented.
    task automatic watch(input int ncyc);
        logic drop_i, drop_d;
        i_lat = -1; d_lat = -1; i_cnt = 0; d_cnt = 0;
        en_cnt = 0; we_cnt = 0; en_first = -1;
        i_rd = '0; d_rd = '0; i_er = 1'b0; d_er = 1'b0; we_addr_s = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            drop_i = 1'b0;
            drop_d = 1'b0;
            if (m_en) begin
                en_cnt++;
                if (en_first < 0) en_first = k;
            end
            if (m_we) begin
                we_cnt++;
                we_addr_s = m_addr;
            end
            if (i_done) begin
                i_cnt++;
                drop_i = 1'b1;
                if (i_lat < 0) begin
                    i_lat = k; i_rd = i_rdata; i_er = i_err;
                end
            end
            if (d_done) begin
                d_cnt++;
                drop_d = 1'b1;
                if (d_lat < 0) begin
                    d_lat = k; d_rd = d_rdata; d_er = d_err;
                end
            end
            @(posedge clk);
            #1;
            if (drop_i) i_req = 1'b0;
            if (drop_d) d_req = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({m_en, m_we, i_done, d_done, i_err, d_err}), 32'd0);
        check({tag, "_bus"}, m_addr | m_wdata | i_rdata | d_rdata, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Aligned load
        d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
        watch(8);
        check("load_lat",      i_lat == -1 ? 32'(d_lat) : 32'hFFFF_FFFF, 32'd3);
        check("load_rdata",    d_rd, 32'h1234_5678);
        check("load_err",      32'(d_er), 32'd0);
        check("load_en_first", 32'(en_first), 32'd1);
        check("load_en_cnt",   32'(en_cnt), 32'd2);
        check("load_we_cnt",   32'(we_cnt), 32'd0);
        check("load_done_cnt", 32'(d_cnt), 32'd1);

        // First tie after reset: D then I
        pulse_reset();
        i_addr = 32'h0; i_req = 1'b1;
        d_we = 1'b0; d_addr = 32'h8; d_req = 1'b1;
        watch(11);
        check("tie1_d_lat",   32'(d_lat), 32'd3);
        check("tie1_i_lat",   32'(i_lat), 32'd7);
        check("tie1_d_rdata", d_rd, 32'h8888_0008);
        check("tie1_i_rdata", i_rd, 32'hCAFE_0000);
        check("tie1_i_cnt",   32'(i_cnt), 32'd1);

        // D alone, then a tie goes to I
        d_addr = 32'h40; d_req = 1'b1;
        watch(6);
        check("solo_d_lat", 32'(d_lat), 32'd3);
        i_addr = 32'h0; i_req = 1'b1;
        d_addr = 32'h8; d_req = 1'b1;
        watch(11);
        check("tie2_i_lat", 32'(i_lat), 32'd3);
        check("tie2_d_lat", 32'(d_lat), 32'd7);
        check("tie2_d_rdata", d_rd, 32'h8888_0008);

        // Store then load back
        d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        watch(6);
        check("store_we_cnt",  32'(we_cnt), 32'd1);
        check("store_we_addr", we_addr_s, 32'h10);
        check("store_lat",     32'(d_lat), 32'd3);
        check("store_rdata",   d_rd, 32'd0);
        d_we = 1'b0; d_wdata = '0; d_addr = 32'h10; d_req = 1'b1;
        watch(6);
        check("readback_rdata", d_rd, 32'hDEAD_BEEF);

        // Misaligned accesses
        d_we = 1'b0; d_addr = 32'h13; d_req = 1'b1;
        watch(4);
        check("mis_d_en_cnt", 32'(en_cnt), 32'd0);
        check("mis_d_lat",    32'(d_lat), 32'd1);
        check("mis_d_err",    32'(d_er), 32'd1);
        check("mis_d_rdata",  d_rd, 32'd0);
        i_addr = 32'h2; i_req = 1'b1;
        watch(4);
        check("mis_i_lat", 32'(i_lat), 32'd1);
        check("mis_i_err", 32'(i_er), 32'd1);

        // Reset in the second ACCESS cycle
        d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_access_en", 32'(m_en), 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        d_req = 1'b0;
        watch(6);
        check("post_reset_done", 32'(i_cnt + d_cnt), 32'd0);
        check("post_reset_en",   32'(en_cnt), 32'd0);
        d_addr = 32'h40; d_req = 1'b1;
        watch(6);
        check("recover_lat",   32'(d_lat), 32'd3);
        check("recover_rdata", d_rd, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32, word width.
REQ-003 Parameter MEM_LAT, default 2, legal range 1..15, memory read latency in cycles.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 i_req  in  1  instruction-fetch request; held with i_addr until i_done.
REQ-007 i_addr  in  ADDR_W  fetch byte address.
REQ-008 i_done  out  1  one-cycle completion pulse for fetch.
REQ-009 i_rdata  out  DATA_W  fetched word; valid while i_done=1.
REQ-010 d_req  in  1  data request; held with d_we, d_addr and d_wdata until d_done.
REQ-011 d_we  in  1  1=store, 0=load.
REQ-012 d_addr  in  ADDR_W  data byte address.
REQ-013 d_wdata  in  DATA_W  store data.
REQ-014 d_done  out  1  one-cycle completion pulse for data.
REQ-015 d_rdata  out  DATA_W  load word; valid while d_done=1.
REQ-016 d_err  out  1  misaligned data access flag; valid with d_done.
REQ-017 i_err  out  1  misaligned fetch flag; valid with i_done.
REQ-018 m_en  out  1  memory enable.
REQ-019 m_we  out  1  memory write strobe.
REQ-020 m_addr  out  ADDR_W  memory word address, byte address with bits [1:0] forced to 0.
REQ-021 m_wdata  out  DATA_W  memory write data.
REQ-022 m_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after m_en rises with m_we=0.

Function
REQ-023 The FSM SHALL use three states, IDLE, ACCESS and RESP, with IDLE as the reset state.
REQ-024 Arbitration SHALL occur only in IDLE; a sole requester wins; if both request, the port not served last wins; after reset the last-served pointer SHALL be the I port, so D wins the first tie.
REQ-025 IDLE→ACCESS SHALL occur on a grant with an aligned address: latch the port, address, we and wdata; load the counter with MEM_LAT-1.
REQ-026 A granted request with addr[1:0]≠0 SHALL go IDLE→RESP directly: no m_en, err=1, rdata=0.
REQ-027 In ACCESS, m_en=1, m_addr and m_wdata SHALL come from the latched values; m_we=1 only in the first ACCESS cycle, and only for a store.
REQ-028 In ACCESS the counter SHALL decrement each cycle; at 0 the block SHALL capture m_rdata into the response register and go to RESP.
REQ-029 In RESP, exactly the granted port's done SHALL be 1 for one cycle; the block SHALL update the last-served pointer and return to IDLE.
REQ-030 Latency from req seen in IDLE to done SHALL be MEM_LAT+1 cycles for an aligned access and 1 cycle for a misaligned access.
REQ-031 A req still high in the cycle after done SHALL be treated as a new request.
REQ-032 For a store, rdata SHALL be 0 on done.
REQ-033 Changes to the other port's req during ACCESS or RESP SHALL have no effect until IDLE.
REQ-034 A request dropped before done (protocol violation) SHALL NOT abort the access; done SHALL still pulse.

Reset
REQ-035 Reset SHALL immediately set state=IDLE, last-served=I, counter=0, and drive all outputs to 0.
REQ-036 On reset during ACCESS, no done SHALL follow; a store whose m_we cycle has already passed is not undone.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RESP) and the port enum (PORT_I, PORT_D).
REQ-038 The block SHALL be a single module with no sub-modules; the counter width SHALL be 4 bits.

Verification (MEM_LAT=2)
REQ-039 Load d_req=1, d_addr=0x40, memory word 0x1234_5678 → m_en high for cycles 1-2, m_we=0, d_done at cycle 3 with d_rdata=0x1234_5678 and d_err=0.
REQ-040 Simultaneous i_req (0x0) and d_req (0x8) after reset → D served first (d_done cycle 3), I served next (i_done cycle 7); a repeated tie → I then D.
REQ-041 Store d_we=1, d_addr=0x10, d_wdata=0xDEAD_BEEF → m_we=1 for exactly one cycle with m_addr=0x10; a later load of 0x10 returns 0xDEAD_BEEF.
REQ-042 d_addr=0x13 → m_en stays 0, d_done at cycle 1 with d_err=1 and d_rdata=0.
REQ-043 Assert reset in the second ACCESS cycle → all outputs 0 in the same cycle, no done pulse, the next request completes normally.
